// File: rtl/mbus_sleep_seq.sv
`default_nettype none
// ============================================================================
// Module      : mbus_sleep_seq
// Description : Power-gating sequencer for one MBus layer (power, clock,
//               reset, isolation ordering on wake and on sleep).
// Revision    : 1.0 - initial release
// ============================================================================
module mbus_sleep_seq #(
  parameter int PWR_DLY = 4,
  parameter int CLK_DLY = 2,
  parameter int RST_DLY = 2,
  parameter int ISO_DLY = 2,
  parameter int CNT_W   = 8
) (
  input  logic CLK,
  input  logic RESETn,
  input  logic WAKEUP_REQ,
  input  logic SLEEP_REQ,
  input  logic EXT_INT_REQ,
  input  logic EXT_INT_CLR,
  output logic POWER_ON,
  output logic RELEASE_CLK,
  output logic RELEASE_RST,
  output logic RELEASE_ISO,
  output logic EXTERNAL_INT,
  output logic BUSY
);

  localparam logic [3:0] c_SLEEP    = 4'd0;
  localparam logic [3:0] c_PWR_UP   = 4'd1;
  localparam logic [3:0] c_CLK_EN   = 4'd2;
  localparam logic [3:0] c_RST_REL  = 4'd3;
  localparam logic [3:0] c_ACTIVE   = 4'd4;
  localparam logic [3:0] c_ISO_HOLD = 4'd5;
  localparam logic [3:0] c_RST_ASRT = 4'd6;
  localparam logic [3:0] c_CLK_GATE = 4'd7;
  localparam logic [3:0] c_PWR_DN   = 4'd8;

  localparam logic [CNT_W-1:0] c_PWR_LD = CNT_W'(PWR_DLY - 1);
  localparam logic [CNT_W-1:0] c_CLK_LD = CNT_W'(CLK_DLY - 1);
  localparam logic [CNT_W-1:0] c_RST_LD = CNT_W'(RST_DLY - 1);
  localparam logic [CNT_W-1:0] c_ISO_LD = CNT_W'(ISO_DLY - 1);

  logic [3:0]       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_power_on, r_release_clk, r_release_rst, r_release_iso;
  logic             r_ext_int, r_busy;
  logic             w_power_on, w_release_clk, w_release_rst, w_release_iso;
  logic             w_ext_int_nxt, w_busy;
  logic             w_wake, w_cnt_zero;

  assign w_wake        = WAKEUP_REQ | EXT_INT_REQ | r_ext_int;
  assign w_cnt_zero    = (r_cnt == '0);
  // Set has priority over clear when both pulse together.
  assign w_ext_int_nxt = EXT_INT_REQ ? 1'b1 : (EXT_INT_CLR ? 1'b0 : r_ext_int);

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      r_state       <= c_SLEEP;
      r_cnt         <= '0;
      r_power_on    <= 1'b0;
      r_release_clk <= 1'b0;
      r_release_rst <= 1'b0;
      r_release_iso <= 1'b0;
      r_ext_int     <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_power_on    <= w_power_on;
      r_release_clk <= w_release_clk;
      r_release_rst <= w_release_rst;
      r_release_iso <= w_release_iso;
      r_ext_int     <= w_ext_int_nxt;
      r_busy        <= w_busy;
    end
  end

  // Each wait state loads DLY-1 on entry and exits on the edge where it reads 0.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = w_cnt_zero ? '0 : r_cnt - 1'b1;
    case (r_state)
      c_SLEEP: if (w_wake) begin
        w_state_nxt = c_PWR_UP;
        w_cnt_nxt   = c_PWR_LD;
      end
      c_PWR_UP: if (w_cnt_zero) begin
        w_state_nxt = c_CLK_EN;
        w_cnt_nxt   = c_CLK_LD;
      end
      c_CLK_EN: if (w_cnt_zero) begin
        w_state_nxt = c_RST_REL;
        w_cnt_nxt   = c_RST_LD;
      end
      c_RST_REL: if (w_cnt_zero) begin
        w_state_nxt = c_ACTIVE;
        w_cnt_nxt   = '0;
      end
      c_ACTIVE: if (SLEEP_REQ && !w_wake) begin
        w_state_nxt = c_ISO_HOLD;
        w_cnt_nxt   = c_ISO_LD;
      end
      c_ISO_HOLD: if (w_cnt_zero) begin
        w_state_nxt = c_RST_ASRT;
        w_cnt_nxt   = c_RST_LD;
      end
      c_RST_ASRT: if (w_cnt_zero) begin
        w_state_nxt = c_CLK_GATE;
        w_cnt_nxt   = c_CLK_LD;
      end
      c_CLK_GATE: if (w_cnt_zero) begin
        w_state_nxt = c_PWR_DN;
        w_cnt_nxt   = c_PWR_LD;
      end
      c_PWR_DN: if (w_cnt_zero) begin
        w_state_nxt = c_SLEEP;
        w_cnt_nxt   = '0;
      end
      default: begin
        w_state_nxt = c_SLEEP;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs decode the next state so the registered copies track the state register.
  always_comb begin
    w_power_on    = 1'b0;
    w_release_clk = 1'b0;
    w_release_rst = 1'b0;
    w_release_iso = 1'b0;
    w_busy        = 1'b1;
    case (w_state_nxt)
      c_SLEEP:    w_busy = 1'b0;
      c_PWR_UP:   w_power_on = 1'b1;
      c_CLK_EN:   {w_power_on, w_release_clk} = 2'b11;
      c_RST_REL:  {w_power_on, w_release_clk, w_release_rst} = 3'b111;
      c_ACTIVE: begin
        {w_power_on, w_release_clk, w_release_rst, w_release_iso} = 4'b1111;
        w_busy = 1'b0;
      end
      c_ISO_HOLD: {w_power_on, w_release_clk, w_release_rst} = 3'b111;
      c_RST_ASRT: {w_power_on, w_release_clk} = 2'b11;
      c_CLK_GATE: w_power_on = 1'b1;
      c_PWR_DN:   w_power_on = 1'b0;
      default:    w_busy = 1'b0;
    endcase
  end

  assign POWER_ON     = r_power_on;
  assign RELEASE_CLK  = r_release_clk;
  assign RELEASE_RST  = r_release_rst;
  assign RELEASE_ISO  = r_release_iso;
  assign EXTERNAL_INT = r_ext_int;
  assign BUSY         = r_busy;

  a_release_order : assert property (@(posedge CLK) disable iff (!RESETn)
    (!RELEASE_ISO || RELEASE_RST) && (!RELEASE_RST || RELEASE_CLK) && (!RELEASE_CLK || POWER_ON));

endmodule
`default_nettype wire

// File: tb/tb_mbus_sleep_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_mbus_sleep_seq
// Description : Vector table, directed corner sequences and random traffic
//               against a latency-based reference model (two delay configs).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mbus_sleep_seq;

  typedef struct packed {
    logic [1:0]  mode;   // 0 sleep, 1 waking, 2 active, 3 shutting down
    logic [15:0] t;      // edges spent in the current sequence
    logic        ext;
  } mst_t;

  typedef struct {
    logic [4:0] in;      // {RESETn, WAKEUP_REQ, SLEEP_REQ, EXT_INT_REQ, EXT_INT_CLR}
    logic [5:0] exp;     // {POWER_ON, RELEASE_CLK, RELEASE_RST, RELEASE_ISO, EXTERNAL_INT, BUSY}
  } vec_t;

  logic       clk;
  logic [4:0] in_vec;
  logic [5:0] o0, o1;
  logic       p0, c0, r0, i0, e0, b0;
  logic       p1, c1, r1, i1, e1, b1;
  mst_t       m0, m1;
  logic       chk_en;
  int         n_checks, n_errors, cyc;
  vec_t       tbl[$];

  mbus_sleep_seq u_dut_def (
    .CLK(clk), .RESETn(in_vec[4]), .WAKEUP_REQ(in_vec[3]), .SLEEP_REQ(in_vec[2]),
    .EXT_INT_REQ(in_vec[1]), .EXT_INT_CLR(in_vec[0]),
    .POWER_ON(p0), .RELEASE_CLK(c0), .RELEASE_RST(r0), .RELEASE_ISO(i0),
    .EXTERNAL_INT(e0), .BUSY(b0));

  mbus_sleep_seq #(.PWR_DLY(1), .CLK_DLY(1), .RST_DLY(1), .ISO_DLY(1), .CNT_W(8)) u_dut_min (
    .CLK(clk), .RESETn(in_vec[4]), .WAKEUP_REQ(in_vec[3]), .SLEEP_REQ(in_vec[2]),
    .EXT_INT_REQ(in_vec[1]), .EXT_INT_CLR(in_vec[0]),
    .POWER_ON(p1), .RELEASE_CLK(c1), .RELEASE_RST(r1), .RELEASE_ISO(i1),
    .EXTERNAL_INT(e1), .BUSY(b1));

  assign o0 = {p0, c0, r0, i0, e0, b0};
  assign o1 = {p1, c1, r1, i1, e1, b1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic mst_t step(mst_t m, logic [4:0] in, int pd, int cd, int rd, int id);
    mst_t n;
    logic wake;
    n    = m;
    wake = in[3] | in[1] | m.ext;
    if (!in[4]) begin
      n = '0;
      return n;
    end
    case (m.mode)
      2'd0: if (wake) begin n.mode = 2'd1; n.t = '0; end
      2'd1: begin
        n.t = m.t + 16'd1;
        if (int'(n.t) == pd + cd + rd) begin n.mode = 2'd2; n.t = '0; end
      end
      2'd2: if (in[2] && !wake) begin n.mode = 2'd3; n.t = '0; end
      default: begin
        n.t = m.t + 16'd1;
        if (int'(n.t) == id + rd + cd + pd) begin n.mode = 2'd0; n.t = '0; end
      end
    endcase
    n.ext = in[1] ? 1'b1 : (in[0] ? 1'b0 : m.ext);
    return n;
  endfunction

  function automatic logic [5:0] outs(mst_t m, int pd, int cd, int rd, int id);
    int t;
    t = int'(m.t);
    case (m.mode)
      2'd0:    return {4'b0000, m.ext, 1'b0};
      2'd1:    return {1'b1, t >= pd, t >= pd + cd, 1'b0, m.ext, 1'b1};
      2'd2:    return {4'b1111, m.ext, 1'b0};
      default: return {t < id + rd + cd, t < id + rd, t < id, 1'b0, m.ext, 1'b1};
    endcase
  endfunction

  function automatic logic ordered(logic [5:0] o);
    return (!o[2] || o[3]) && (!o[3] || o[4]) && (!o[4] || o[5]);
  endfunction

  always @(posedge clk) begin
    m0 <= step(m0, in_vec, 4, 2, 2, 2);
    m1 <= step(m1, in_vec, 1, 1, 1, 1);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      n_checks = n_checks + 4;
      if (o0 !== outs(m0, 4, 2, 2, 2)) begin
        n_errors = n_errors + 1;
        $display("FAIL model_def cyc %0d got %b expected %b", cyc, o0, outs(m0, 4, 2, 2, 2));
      end
      if (o1 !== outs(m1, 1, 1, 1, 1)) begin
        n_errors = n_errors + 1;
        $display("FAIL model_min cyc %0d got %b expected %b", cyc, o1, outs(m1, 1, 1, 1, 1));
      end
      if (!ordered(o0)) begin
        n_errors = n_errors + 1;
        $display("FAIL order_def cyc %0d got %b expected ordered releases", cyc, o0);
      end
      if (!ordered(o1)) begin
        n_errors = n_errors + 1;
        $display("FAIL order_min cyc %0d got %b expected ordered releases", cyc, o1);
      end
    end
  end

  task automatic add(input logic [4:0] in, input logic [5:0] exp, input int n);
    vec_t v;
    v.in  = in;
    v.exp = exp;
    for (int k = 0; k < n; k++) tbl.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc = cyc + 1;
  endtask

  initial begin
    logic w, s;
    in_vec   = 5'b00000;
    chk_en   = 1'b0;
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;

    // reset and idle
    add(5'b00000, 6'b000000, 2);
    add(5'b10000, 6'b000000, 1);
    // wake on WAKEUP_REQ
    add(5'b11000, 6'b100001, 4);
    add(5'b11000, 6'b110001, 2);
    add(5'b11000, 6'b111001, 2);
    add(5'b11000, 6'b111100, 1);
    // sleep on SLEEP_REQ
    add(5'b10100, 6'b111001, 2);
    add(5'b10100, 6'b110001, 2);
    add(5'b10100, 6'b100001, 2);
    add(5'b10100, 6'b000001, 4);
    add(5'b10100, 6'b000000, 1);
    // external interrupt wake, clear, set-wins tie
    add(5'b10010, 6'b100011, 1);
    add(5'b10000, 6'b100011, 3);
    add(5'b10000, 6'b110011, 2);
    add(5'b10000, 6'b111011, 2);
    add(5'b10000, 6'b111110, 1);
    add(5'b10001, 6'b111100, 1);
    add(5'b10011, 6'b111110, 1);
    add(5'b10001, 6'b111100, 1);
    // sleep/wake tie stays active; wake during CLK_GATE finishes shutdown first
    add(5'b11100, 6'b111100, 2);
    add(5'b10100, 6'b111001, 2);
    add(5'b10100, 6'b110001, 2);
    add(5'b11000, 6'b100001, 2);
    add(5'b11000, 6'b000001, 4);
    add(5'b11000, 6'b000000, 1);
    add(5'b11000, 6'b100001, 4);
    add(5'b11000, 6'b110001, 2);
    add(5'b11000, 6'b111001, 1);
    // one-edge reset during RST_REL, then a fresh wake
    add(5'b01000, 6'b000000, 1);
    add(5'b11000, 6'b100001, 1);
    add(5'b10000, 6'b100001, 3);
    add(5'b10000, 6'b110001, 2);
    add(5'b10000, 6'b111001, 2);
    add(5'b10000, 6'b111100, 1);

    @(negedge clk);
    foreach (tbl[i]) begin
      in_vec = tbl[i].in;
      tick();
      chk_en   = 1'b1;
      n_checks = n_checks + 1;
      if (o0 !== tbl[i].exp) begin
        n_errors = n_errors + 1;
        $display("FAIL vec[%0d] got %b expected %b", i, o0, tbl[i].exp);
      end
    end

    w = 1'b0;
    s = 1'b0;
    for (int k = 0; k < 10000; k++) begin
      if ($urandom_range(0, 15) == 0) w = ~w;
      if ($urandom_range(0, 11) == 0) s = ~s;
      in_vec = {($urandom_range(0, 499) != 0), w, s,
                ($urandom_range(0, 39) == 0), ($urandom_range(0, 19) == 0)};
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
